pmem_arbiter: RTL and testbench

//  Shares one 256-bit physical-memory port between the I-cache (read-only line fills)
//  and the D-cache (line fills and write-backs). Sits between both caches and the

---
 rtl/cache_types_pkg.sv | 26 ++
 rtl/pmem_arb_select.sv | 26 ++
 rtl/pmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_pmem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cache_types                                                  |
// | Description : Types shared by the caches and the physical-memory arbiter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cache_types;

    localparam int CACHE_LINE_W = 256;

    typedef logic [CACHE_LINE_W-1:0] pmem_line_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } pmem_arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } pmem_grant_t;

endpackage
`default_nettype wire

// File: rtl/pmem_arb_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pmem_arb_select                                              |
// | Description : Combinational two-way winner pick. A lone requester always   |
// |               wins; a tie goes to the requester that was not served last.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pmem_arb_select
    import cache_types::*;
(
    input  logic        i_icache_req,
    input  logic        i_dcache_req,
    input  pmem_grant_t i_last_grant,
    output pmem_grant_t o_grant
);

    // D wins when alone, or on a tie when I was the last one served.
    always_comb begin
        o_grant = GRANT_I;
        if (i_dcache_req && (!i_icache_req || (i_last_grant == GRANT_I))) begin
            o_grant = GRANT_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pmem_arbiter                                                 |
// | Description : Shares one line-wide memory port between the I-cache and the |
// |               D-cache. The winning command is registered and held until    |
// |               pmem_resp; the completion is routed to the winner only.      |
// |               Build option PMEM_ARB_RR_EN: round-robin tie-break instead   |
// |               of fixed D-over-I priority.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pmem_arbiter
    import cache_types::*;
#(
    parameter int LINE_W = CACHE_LINE_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    pmem_arb_state_t   r_state;
    pmem_arb_state_t   w_state_next;
    pmem_grant_t       w_grant;
    pmem_grant_t       w_last_grant;
    logic              w_d_req;
    logic              w_load;
    logic              w_clear;
    logic [ADDR_W-1:0] r_pmem_address;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [LINE_W-1:0] r_pmem_wdata;

    assign w_d_req = d_pmem_read | d_pmem_write;

    pmem_arb_select u_select (
        .i_icache_req (i_pmem_read),
        .i_dcache_req (w_d_req),
        .i_last_grant (w_last_grant),
        .o_grant      (w_grant)
    );

`ifdef PMEM_ARB_RR_EN
    pmem_grant_t r_last_grant;

    // Remember who was served last so the next tie goes to the other cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_I;
        end else if (w_load) begin
            r_last_grant <= w_grant;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    // Pretending I was always served last hands every tie to the D-cache.
    assign w_last_grant = GRANT_I;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: grant only from IDLE, complete on pmem_resp, spend one cycle in DONE.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_pmem_read || w_d_req) begin
                    w_load       = 1'b1;
                    w_state_next = (w_grant == GRANT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    w_clear      = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Command register: capture the winner once, hold it, drop read/write on completion.
    // A D request with both read and write set is treated as a write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_address <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_wdata   <= '0;
        end else if (w_load) begin
            if (w_grant == GRANT_D) begin
                r_pmem_address <= d_pmem_address;
                r_pmem_read    <= ~d_pmem_write;
                r_pmem_write   <= d_pmem_write;
                r_pmem_wdata   <= d_pmem_wdata;
            end else begin
                r_pmem_address <= i_pmem_address;
                r_pmem_read    <= 1'b1;
                r_pmem_write   <= 1'b0;
            end
        end else if (w_clear) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end
    end

    assign pmem_address = r_pmem_address;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_wdata   = r_pmem_wdata;

    // Read data is broadcast; only the completion strobe is steered.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = (r_state == SERVE_I) & pmem_resp;
    assign d_pmem_resp  = (r_state == SERVE_D) & pmem_resp;

`ifndef SYNTHESIS
    a_d_read_write_exclusive : assert property (
        @(posedge clk) disable iff (!rst_n) !(d_pmem_read && d_pmem_write)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pmem_arbiter                                              |
// | Description : Self-checking bench for pmem_arbiter: a bus-ownership model  |
// |               checked every cycle, directed scenarios with literal         |
// |               expectations, then randomized caches and memory.             |
// |               Honours PMEM_ARB_RR_EN for the expected tie-break.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pmem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic          i_pmem_read = 1'b0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic [AW-1:0] d_pmem_address = '0;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic [AW-1:0] pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    pmem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_address   (pmem_address),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: who owns the memory port and what it asked for.
    // owner 0 = free, 1 = I-cache, 2 = D-cache. After a completion the
    // port rests for one cycle before anybody can be granted again.
    // ------------------------------------------------------------------
    int            m_owner;
    logic [AW-1:0] m_addr;
    logic          m_rd, m_wr;
    logic [LW-1:0] m_wdata;
    bit            m_rest;
    bit            m_last_d;
    bit            m_ireq, m_dreq, m_pick_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0; m_addr = '0; m_rd = 0; m_wr = 0; m_wdata = '0;
            m_rest = 0; m_last_d = 0;
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                m_owner = 0; m_rd = 0; m_wr = 0; m_rest = 1;
            end
        end else if (m_rest) begin
            m_rest = 0;
        end else begin
            m_ireq = i_pmem_read;
            m_dreq = d_pmem_read | d_pmem_write;
`ifdef PMEM_ARB_RR_EN
            m_pick_d = m_dreq && (!m_ireq || !m_last_d);
`else
            m_pick_d = m_dreq;
`endif
            if (m_pick_d) begin
                m_owner = 2; m_addr = d_pmem_address; m_wr = d_pmem_write;
                m_rd = !d_pmem_write; m_wdata = d_pmem_wdata; m_last_d = 1;
            end else if (m_ireq) begin
                m_owner = 1; m_addr = i_pmem_address; m_rd = 1; m_wr = 0; m_last_d = 0;
            end
        end
    end

    // Compare DUT against the model in the middle of every cycle.
    bit exp_iresp, exp_dresp;
    always @(negedge clk) begin
        exp_iresp = (m_owner == 1) && pmem_resp;
        exp_dresp = (m_owner == 2) && pmem_resp;
        chk("cyc_pmem_address", pmem_address, m_addr);
        chk("cyc_pmem_cmd", {pmem_read, pmem_write}, {m_rd, m_wr});
        chk("cyc_pmem_wdata", pmem_wdata, m_wdata);
        chk("cyc_resp", {i_pmem_resp, d_pmem_resp}, {exp_iresp, exp_dresp});
        if (exp_iresp) chk("cyc_i_rdata", i_pmem_rdata, pmem_rdata);
        if (exp_dresp) chk("cyc_d_rdata", d_pmem_rdata, pmem_rdata);
    end

    // ------------------------------------------------------------------
    // Memory: answers a visible command after mem_delay cycles; can also
    // inject stray responses while no command is out.
    // ------------------------------------------------------------------
    int mem_cnt = 0;
    int mem_delay = 5;
    bit mem_auto = 1'b0, mem_rand = 1'b0, mem_spur = 1'b0, man_resp = 1'b0;

    always @(posedge clk) begin
        #1;
        if (pmem_read || pmem_write) mem_cnt++;
        else begin
            mem_cnt = 0;
            if (mem_rand) mem_delay = $urandom_range(1, 6);
        end
        if (mem_auto && mem_cnt == mem_delay + 1) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rand_line();
        end else begin
            pmem_resp = man_resp ||
                        (mem_spur && !(pmem_read || pmem_write) && $urandom_range(0, 5) == 0);
            if (pmem_resp) pmem_rdata = rand_line();
        end
    end

    // ------------------------------------------------------------------
    // Directed-scenario recorder. Index k counts mid-cycle samples from
    // the cycle the requests were first driven.
    // ------------------------------------------------------------------
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic [LW-1:0] wdata;
    } cmd_t;

    cmd_t cmds[$];
    int   iresp[$];
    int   dresp[$];
    int   rd_high;

    task automatic watch(input int n, input bit hold, input int drop_i_at,
                         input bit d_chain, input logic [AW-1:0] chain_addr);
        bit prev_cmd, gi, gd, chained;
        cmds.delete(); iresp.delete(); dresp.delete();
        rd_high = 0; prev_cmd = 0; chained = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (pmem_read) rd_high++;
            if ((pmem_read || pmem_write) && !prev_cmd)
                cmds.push_back('{k, pmem_address, pmem_read, pmem_write, pmem_wdata});
            prev_cmd = pmem_read || pmem_write;
            gi = i_pmem_resp;
            gd = d_pmem_resp;
            if (gi) iresp.push_back(k);
            if (gd) dresp.push_back(k);
            @(posedge clk); #1;
            if (k == drop_i_at) i_pmem_read = 1'b0;
            if (gi && !hold) i_pmem_read = 1'b0;
            if (gd && !hold) begin
                if (d_chain && !chained) begin
                    chained = 1; d_pmem_write = 1'b0; d_pmem_read = 1'b1;
                    d_pmem_address = chain_addr;
                end else begin
                    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [LW-1:0] wd4;
    logic [AW-1:0] exp_a;
    bit            seen, gi_r, gd_r;

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_i_resp", i_pmem_resp, 0);
        chk("rst_d_resp", d_pmem_resp, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        mem_auto = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Lone I fill, memory answers 5 cycles after the command.
        mem_delay = 5;
        i_pmem_address = 32'h0000_0060; i_pmem_read = 1'b1;
        watch(12, 0, -1, 0, '0);
        chk("t2_ncmd", cmds.size(), 1);
        chk("t2_niresp", iresp.size(), 1);
        chk("t2_ndresp", dresp.size(), 0);
        if (cmds.size() >= 1 && iresp.size() >= 1) begin
            chk("t2_cmd_cycle", cmds[0].cyc, 1);
            chk("t2_addr", cmds[0].addr, 32'h60);
            chk("t2_is_read", {cmds[0].rd, cmds[0].wr}, 2'b10);
            chk("t2_latency", iresp[0] - cmds[0].cyc, 5);
        end

        // Simultaneous I read and D write-back: D first.
        mem_delay = 3;
        i_pmem_address = 32'h100; i_pmem_read = 1'b1;
        d_pmem_address = 32'h200; d_pmem_write = 1'b1; d_pmem_wdata = {32{8'hA5}};
        watch(16, 0, -1, 0, '0);
        chk("t3_ncmd", cmds.size(), 2);
        chk("t3_ndresp", dresp.size(), 1);
        chk("t3_niresp", iresp.size(), 1);
        if (cmds.size() >= 2 && dresp.size() >= 1) begin
            chk("t3_first_write", {cmds[0].rd, cmds[0].wr}, 2'b01);
            chk("t3_first_addr", cmds[0].addr, 32'h200);
            chk("t3_first_wdata", cmds[0].wdata, {32{8'hA5}});
            chk("t3_second_addr", cmds[1].addr, 32'h100);
            chk("t3_second_read", {cmds[1].rd, cmds[1].wr}, 2'b10);
            // Response sampled on edge E, next command launched on edge E+2.
            chk("t3_gap", cmds[1].cyc - dresp[0], 3);
        end

        // Dirty eviction: D write then D read, I waiting throughout.
        mem_delay = 2;
        wd4 = rand_line();
        i_pmem_address = 32'h500; i_pmem_read = 1'b1;
        d_pmem_address = 32'h300; d_pmem_write = 1'b1; d_pmem_wdata = wd4;
        watch(20, 0, -1, 1, 32'h400);
        chk("t4_ncmd", cmds.size(), 3);
        chk("t4_ndresp", dresp.size(), 2);
        if (cmds.size() >= 3 && dresp.size() >= 1) begin
            chk("t4_wb_addr", cmds[0].addr, 32'h300);
            chk("t4_wb_data", cmds[0].wdata, wd4);
`ifdef PMEM_ARB_RR_EN
            chk("t4_second_addr", cmds[1].addr, 32'h500);
            chk("t4_third_addr", cmds[2].addr, 32'h400);
`else
            chk("t4_second_addr", cmds[1].addr, 32'h400);
            chk("t4_third_addr", cmds[2].addr, 32'h500);
`endif
            chk("t4_gap", cmds[1].cyc - dresp[0], 3);
        end

        // I drops its request one cycle into service.
        mem_delay = 4;
        i_pmem_address = 32'h7C0; i_pmem_read = 1'b1;
        watch(10, 0, 1, 0, '0);
        chk("t6_niresp", iresp.size(), 1);
        chk("t6_read_high_cycles", rd_high, 5);

        // Both request continuously after a fresh reset.
        do_reset();
        mem_delay = 2;
        i_pmem_address = 32'hA00; i_pmem_read = 1'b1;
        d_pmem_address = 32'hB00; d_pmem_read = 1'b1;
        watch(22, 1, -1, 0, '0);
        chk("t5_ncmd_min4", cmds.size() >= 4, 1);
        for (int j = 0; j < 4 && j < cmds.size(); j++) begin
`ifdef PMEM_ARB_RR_EN
            exp_a = (j % 2 == 0) ? 32'hB00 : 32'hA00;
`else
            exp_a = 32'hB00;
`endif
            chk($sformatf("t5_grant%0d", j), cmds[j].addr, exp_a);
        end
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        repeat (8) @(posedge clk); #1;

        // Reset in the middle of a D write-back; a late response is ignored.
        mem_auto = 1'b0;
        d_pmem_address = 32'h200; d_pmem_write = 1'b1; d_pmem_wdata = rand_line();
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            seen = pmem_write;
        end
        chk("t1_write_issued", seen, 1);
        #2 rst_n = 1'b0;
        d_pmem_write = 1'b0;
        #1;
        chk("t1_write_cleared_async", pmem_write, 0);
        chk("t1_addr_cleared_async", pmem_address, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk) man_resp = 1'b1;
        @(negedge clk);
        chk("t1_late_resp_ignored", {i_pmem_resp, d_pmem_resp}, 2'b00);
        man_resp = 1'b0;
        @(posedge clk); #1;

        // Randomized caches and memory, checked cycle by cycle against the model.
        mem_auto = 1'b1; mem_rand = 1'b1; mem_spur = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gi_r = i_pmem_resp;
            gd_r = d_pmem_resp;
            @(posedge clk); #1;
            if (gi_r) i_pmem_read = 1'b0;
            else if (!i_pmem_read && $urandom_range(0, 3) == 0) begin
                i_pmem_read = 1'b1;
                i_pmem_address = $urandom & ~32'h1F;
            end else if (i_pmem_read && $urandom_range(0, 39) == 0) i_pmem_read = 1'b0;
            if (gd_r) begin
                d_pmem_read = 1'b0; d_pmem_write = 1'b0;
            end else if (!d_pmem_read && !d_pmem_write && $urandom_range(0, 3) == 0) begin
                d_pmem_address = $urandom & ~32'h1F;
                d_pmem_wdata = rand_line();
                if ($urandom_range(0, 1) == 1) d_pmem_write = 1'b1;
                else d_pmem_read = 1'b1;
            end
        end
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
